// File: rtl/spatial_mac_array.sv
// rtl/spatial_mac_array.sv - ROWSxCOLS multiply-accumulate array with windows, clear and overflow flags
// Optional build macro: SPATIAL_ACC_SAT_EN (saturating accumulators instead of wrapping).
module spatial_mac_array #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DW    = 16,
  parameter int AW    = 32,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     acc_clr,
  input  logic [CNT_W-1:0]         acc_len,
  input  logic [ROWS*COLS*DW-1:0]  weight,
  input  logic [ROWS*COLS*DW-1:0]  inputt,
  output logic [ROWS*COLS*AW-1:0]  outputt,
  output logic                     out_valid,
  output logic                     done,
  output logic [CNT_W-1:0]         beat_cnt,
  output logic [ROWS*COLS-1:0]     ovf
);

  localparam int N = ROWS * COLS;

  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q;
  logic             done_q;
  logic             win_end_q;

  logic             fresh;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_nx;
  logic             win_hit;

  // A beat starts a new window after a clear or once the previous window completed.
  always_comb begin
    fresh   = acc_clr | win_end_q;
    cnt_inc = cnt_q;
    if (!((acc_len == '0) && (&cnt_q))) begin
      cnt_inc = cnt_q + CNT_W'(1);
    end
    cnt_nx  = fresh ? CNT_W'(1) : cnt_inc;
    win_hit = (acc_len != '0) && (cnt_nx == acc_len);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      win_end_q   <= 1'b0;
    end else if (in_valid) begin
      cnt_q       <= cnt_nx;
      out_valid_q <= 1'b1;
      done_q      <= win_hit;
      win_end_q   <= win_hit;
    end else begin
      done_q <= 1'b0;
      if (acc_clr) begin
        cnt_q       <= '0;
        out_valid_q <= 1'b0;
        win_end_q   <= 1'b0;
      end
    end
  end

  assign beat_cnt  = cnt_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [2*DW-1:0] prod;
    logic [AW-1:0]   p_ext;
    logic [AW:0]     sum;
    logic [AW-1:0]   acc_r;
    logic            ovf_r;

    assign prod  = {{DW{1'b0}}, weight[k*DW +: DW]} * {{DW{1'b0}}, inputt[k*DW +: DW]};
    assign p_ext = AW'(prod);
    assign sum   = {1'b0, acc_r} + {1'b0, p_ext};

    always_ff @(posedge clk) begin
      if (rst) begin
        acc_r <= '0;
        ovf_r <= 1'b0;
      end else if (in_valid) begin
        if (fresh) begin
          acc_r <= p_ext;
          ovf_r <= 1'b0;
        end else begin
          if (sum[AW]) begin
            ovf_r <= 1'b1;
          end
`ifdef SPATIAL_ACC_SAT_EN
          acc_r <= sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
`else
          acc_r <= sum[AW-1:0];
`endif
        end
      end else if (acc_clr) begin
        acc_r <= '0;
        ovf_r <= 1'b0;
      end
    end

    assign outputt[k*AW +: AW] = acc_r;
    assign ovf[k]              = ovf_r;
  end

endmodule

// File: tb/tb_spatial_mac_array.sv
// tb/tb_spatial_mac_array.sv - directed table-driven bench for spatial_mac_array
module tb_spatial_mac_array;

  localparam int N = 16;

`ifdef SPATIAL_ACC_SAT_EN
  localparam logic [31:0] BIG2 = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] BIG2 = 32'hFFFC_0002;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          acc_clr = 1'b0;
  logic [7:0]    acc_len = '0;
  logic [N*16-1:0] weight = '0;
  logic [N*16-1:0] inputt = '0;
  logic [N*32-1:0] outputt;
  logic          out_valid;
  logic          done;
  logic [7:0]    beat_cnt;
  logic [N-1:0]  ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spatial_mac_array dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .acc_clr(acc_clr), .acc_len(acc_len),
    .weight(weight), .inputt(inputt), .outputt(outputt), .out_valid(out_valid),
    .done(done), .beat_cnt(beat_cnt), .ovf(ovf)
  );

  typedef struct {
    string       name;
    logic        rst, clr, vld;
    logic [7:0]  len;
    bit          big;
    logic [31:0] exp_m;
    logic [7:0]  exp_cnt;
    logic        exp_done, exp_ov, exp_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic r, logic c, logic v, logic [7:0] l, bit b,
                              logic [31:0] m, logic [7:0] cn, logic d, logic ov, logic of);
    vec_t t;
    t.name = nm; t.rst = r; t.clr = c; t.vld = v; t.len = l; t.big = b;
    t.exp_m = m; t.exp_cnt = cn; t.exp_done = d; t.exp_ov = ov; t.exp_ovf = of;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic set_ops(bit b);
    for (int k = 0; k < N; k++) begin
      weight[k*16 +: 16] = b ? 16'hFFFF : 16'(k + 1);
      inputt[k*16 +: 16] = b ? 16'hFFFF : 16'(k + 1);
    end
  endtask

  task automatic check_lanes(string nm, bit b, logic [31:0] m);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s.out[%0d]", nm, k), outputt[k*32 +: 32],
          b ? m : m * 32'((k + 1) * (k + 1)));
    end
  endtask

  initial begin
    int done_seen;

    // name, rst, clr, vld, len, big, exp_m, exp_cnt, exp_done, exp_ov, exp_ovf
    tbl.push_back(mk("reset",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("beat1",     0, 0, 1, 0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk("beat2",     0, 0, 1, 0, 0, 2, 2, 0, 1, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk("hold",    0, 0, 0, 0, 0, 2, 2, 0, 1, 0));
    tbl.push_back(mk("clr_vld",   0, 1, 1, 0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk("b2",        0, 0, 1, 0, 0, 2, 2, 0, 1, 0));
    tbl.push_back(mk("b3",        0, 0, 1, 0, 0, 3, 3, 0, 1, 0));
    tbl.push_back(mk("clr_only",  0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("win_b1",    0, 0, 1, 2, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk("win_b2",    0, 0, 1, 2, 0, 2, 2, 1, 1, 0));
    tbl.push_back(mk("win_b3",    0, 0, 1, 2, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk("win_idle",  0, 0, 0, 2, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk("rst2",      1, 0, 0, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("l3_b1",     0, 0, 1, 3, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk("rst_mid",   1, 0, 0, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("l3_r1",     0, 0, 1, 3, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk("l3_r2",     0, 0, 1, 3, 0, 2, 2, 0, 1, 0));
    tbl.push_back(mk("l3_r3",     0, 0, 1, 3, 0, 3, 3, 1, 1, 0));
    tbl.push_back(mk("big1",      0, 1, 1, 0, 1, 32'hFFFE_0001, 1, 0, 1, 0));
    tbl.push_back(mk("big2",      0, 0, 1, 0, 1, BIG2, 2, 0, 1, 1));
    tbl.push_back(mk("big_clr",   0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("len1_a",    0, 1, 1, 1, 0, 1, 1, 1, 1, 0));
    tbl.push_back(mk("len1_b",    0, 0, 1, 1, 0, 1, 1, 1, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst      = tbl[i].rst;
      acc_clr  = tbl[i].clr;
      in_valid = tbl[i].vld;
      acc_len  = tbl[i].len;
      set_ops(tbl[i].big);
      @(posedge clk);
      #1;
      check_lanes(tbl[i].name, tbl[i].big, tbl[i].exp_m);
      chk({tbl[i].name, ".beat_cnt"},  32'(beat_cnt),  32'(tbl[i].exp_cnt));
      chk({tbl[i].name, ".done"},      32'(done),      32'(tbl[i].exp_done));
      chk({tbl[i].name, ".out_valid"}, 32'(out_valid), 32'(tbl[i].exp_ov));
      chk({tbl[i].name, ".ovf"},       32'(ovf),       tbl[i].exp_ovf ? 32'h0000_FFFF : 32'h0);
    end

    // Free-running window: beat_cnt saturates while the sums keep growing.
    done_seen = 0;
    set_ops(1'b0);
    acc_len  = 8'd0;
    rst      = 1'b0;
    for (int i = 0; i < 300; i++) begin
      acc_clr  = (i == 0);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    acc_clr  = 1'b0;
    in_valid = 1'b0;
    chk("sat.beat_cnt", 32'(beat_cnt), 32'd255);
    chk("sat.done_seen", 32'(done_seen), 32'd0);
    chk("sat.out[0]", outputt[0 +: 32], 32'd300);
    chk("sat.out[15]", outputt[15*32 +: 32], 32'd76800);
    chk("sat.ovf", 32'(ovf), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
